// File: rtl/ram_port_arbiter_if.sv
// Requester-side bundle for ram_port_arbiter: two command channels with valid/ready handshake
// and two read-response channels (pulse, no backpressure).
interface ram_port_arbiter_if #(
  parameter int unsigned D_WIDTH = 16,
  parameter int unsigned A_WIDTH = 5
);
  logic               req0_valid;
  logic               req0_write;
  logic [A_WIDTH-1:0] req0_address;
  logic [D_WIDTH-1:0] req0_data;
  logic               req0_ready;
  logic               rsp0_valid;
  logic [D_WIDTH-1:0] rsp0_data;

  logic               req1_valid;
  logic               req1_write;
  logic [A_WIDTH-1:0] req1_address;
  logic [D_WIDTH-1:0] req1_data;
  logic               req1_ready;
  logic               rsp1_valid;
  logic [D_WIDTH-1:0] rsp1_data;

  modport master (
    output req0_valid, req0_write, req0_address, req0_data,
    input  req0_ready, rsp0_valid, rsp0_data,
    output req1_valid, req1_write, req1_address, req1_data,
    input  req1_ready, rsp1_valid, rsp1_data
  );

  modport slave (
    input  req0_valid, req0_write, req0_address, req0_data,
    output req0_ready, rsp0_valid, rsp0_data,
    input  req1_valid, req1_write, req1_address, req1_data,
    output req1_ready, rsp1_valid, rsp1_data
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter/sequencer sharing one write port and one registered read port of a RAM
// between two requesters; one command in flight at a time.
module ram_port_arbiter #(
  parameter int unsigned D_WIDTH = 16,
  parameter int unsigned A_WIDTH = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  ram_port_arbiter_if.slave  bus,
  output logic [A_WIDTH-1:0] o_ram_address_write,
  output logic [D_WIDTH-1:0] o_ram_data_write,
  output logic               o_ram_write_enable,
  output logic [A_WIDTH-1:0] o_ram_address_read,
  input  logic [D_WIDTH-1:0] i_ram_data_read
);

  typedef enum logic [1:0] {StIdle, StWr, StRd, StRwait} state_e;

  state_e r_state;
  state_e w_state_next;

  logic               r_prio;
  logic               r_owner;
  logic               r_write_enable;
  logic [A_WIDTH-1:0] r_address_write;
  logic [D_WIDTH-1:0] r_data_write;
  logic [A_WIDTH-1:0] r_address_read;
  logic               r_rsp0_valid;
  logic               r_rsp1_valid;
  logic [D_WIDTH-1:0] r_rsp0_data;
  logic [D_WIDTH-1:0] r_rsp1_data;

  logic               w_grant;
  logic               w_hs;
  logic               w_cmd_write;
  logic [A_WIDTH-1:0] w_cmd_address;
  logic [D_WIDTH-1:0] w_cmd_data;

  // A lone requester wins outright; on a tie the priority bit picks the winner.
  always_comb begin
    w_grant       = (bus.req0_valid && bus.req1_valid) ? r_prio : bus.req1_valid;
    w_hs          = (r_state == StIdle) && (bus.req0_valid || bus.req1_valid);
    w_cmd_write   = w_grant ? bus.req1_write   : bus.req0_write;
    w_cmd_address = w_grant ? bus.req1_address : bus.req0_address;
    w_cmd_data    = w_grant ? bus.req1_data    : bus.req0_data;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_hs) w_state_next = w_cmd_write ? StWr : StRd;
      StWr:    w_state_next = StIdle;
      StRd:    w_state_next = StRwait;
      StRwait: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= StIdle;
      r_prio          <= 1'b0;
      r_owner         <= 1'b0;
      r_write_enable  <= 1'b0;
      r_address_write <= '0;
      r_data_write    <= '0;
      r_address_read  <= '0;
      r_rsp0_valid    <= 1'b0;
      r_rsp1_valid    <= 1'b0;
      r_rsp0_data     <= '0;
      r_rsp1_data     <= '0;
    end else begin
      r_state        <= w_state_next;
      r_write_enable <= (w_state_next == StWr);
      r_rsp0_valid   <= 1'b0;
      r_rsp1_valid   <= 1'b0;
      if (w_hs) begin
        r_prio  <= ~w_grant;
        r_owner <= w_grant;
        if (w_cmd_write) begin
          r_address_write <= w_cmd_address;
          r_data_write    <= w_cmd_data;
        end else begin
          r_address_read  <= w_cmd_address;
        end
      end
      // RAM read data is valid during RWAIT; capture it for the owner of the read.
      if (r_state == StRwait) begin
        if (r_owner) begin
          r_rsp1_valid <= 1'b1;
          r_rsp1_data  <= i_ram_data_read;
        end else begin
          r_rsp0_valid <= 1'b1;
          r_rsp0_data  <= i_ram_data_read;
        end
      end
    end
  end

  assign bus.req0_ready = w_hs && !w_grant;
  assign bus.req1_ready = w_hs && w_grant;
  assign bus.rsp0_valid = r_rsp0_valid;
  assign bus.rsp1_valid = r_rsp1_valid;
  assign bus.rsp0_data  = r_rsp0_data;
  assign bus.rsp1_data  = r_rsp1_data;

  assign o_ram_address_write = r_address_write;
  assign o_ram_data_write    = r_data_write;
  assign o_ram_write_enable  = r_write_enable;
  assign o_ram_address_read  = r_address_read;

endmodule
